rggen_apb_register_adapter: RTL and testbench



---
 rtl/rggen_apb_register_adapter_pkg.sv | 19 +
 rtl/rggen_apb_response_mux.sv | 30 +++
 rtl/rggen_apb_register_adapter.sv | 189 ++++++++++++++++++
 tb/tb_rggen_apb_register_adapter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_apb_register_adapter_pkg.sv
// Shared types and rggen bus encodings for the APB register adapter.
// Access codes and the status error bit position are defined once here for all adapter files.
package rggen_apb_register_adapter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_e;

  localparam logic [1:0] RGGEN_ACCESS_READ  = 2'b10;
  localparam logic [1:0] RGGEN_ACCESS_WRITE = 2'b11;
  localparam int         RGGEN_STATUS_ERROR_BIT = 1;

  function automatic logic [1:0] access_code(input logic write);
    return write ? RGGEN_ACCESS_WRITE : RGGEN_ACCESS_READ;
  endfunction

endpackage

// File: rtl/rggen_apb_response_mux.sv
// OR-reduces read data and error status over the register blocks that completed this cycle.
module rggen_apb_response_mux
  import rggen_apb_register_adapter_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int REGISTERS = 1
)(
  input  logic [REGISTERS-1:0]           hit,
  input  logic [BUS_WIDTH*REGISTERS-1:0] read_data,
  input  logic [2*REGISTERS-1:0]         status,
  output logic [BUS_WIDTH-1:0]           selected_data,
  output logic                           selected_error
);

  // Only the status error bit is meaningful to the adapter; the rest is folded away here.
  logic unused_status;
  assign unused_status = ^status;

  always_comb begin
    selected_data  = '0;
    selected_error = 1'b0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (hit[i]) begin
        selected_data  = selected_data | read_data[i*BUS_WIDTH +: BUS_WIDTH];
        selected_error = selected_error | status[2*i + RGGEN_STATUS_ERROR_BIT];
      end
    end
  end

endmodule

// File: rtl/rggen_apb_register_adapter.sv
// APB slave to rggen register-bus adapter with an IDLE/BUSY/RESPOND handshake.
// Define RGGEN_APB_ADAPTER_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES without ready.
module rggen_apb_register_adapter
  import rggen_apb_register_adapter_pkg::*;
#(
  parameter int              ADDRESS_WIDTH  = 8,
  parameter longint unsigned BASE_ADDRESS   = 0,
  parameter longint unsigned BYTE_SIZE      = 256,
  parameter int              BUS_WIDTH      = 32,
  parameter int              REGISTERS      = 1,
  parameter int              ERROR_STATUS   = 0,
  parameter int              TIMEOUT_CYCLES = 16
)(
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_psel,
  input  logic                           i_penable,
  input  logic                           i_pwrite,
  input  logic [ADDRESS_WIDTH-1:0]       i_paddr,
  input  logic [2:0]                     i_pprot,
  input  logic [BUS_WIDTH/8-1:0]         i_pstrb,
  input  logic [BUS_WIDTH-1:0]           i_pwdata,
  output logic                           o_pready,
  output logic                           o_pslverr,
  output logic [BUS_WIDTH-1:0]           o_prdata,
  output logic                           o_register_valid,
  output logic [1:0]                     o_register_access,
  output logic [ADDRESS_WIDTH-1:0]       o_register_address,
  output logic [BUS_WIDTH-1:0]           o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]         o_register_strobe,
  input  logic [REGISTERS-1:0]           i_register_active,
  input  logic [REGISTERS-1:0]           i_register_ready,
  input  logic [2*REGISTERS-1:0]         i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

  state_e state;
  state_e state_next;

  logic [63:0]              paddr_ext;
  logic                     in_window;
  logic [ADDRESS_WIDTH-1:0] offset_q;
  logic                     write_q;
  logic [BUS_WIDTH-1:0]     wdata_q;
  logic [BUS_WIDTH/8-1:0]   strobe_q;
  logic [BUS_WIDTH-1:0]     rdata_q;
  logic                     status_err_q;
  logic                     decode_err_q;
  logic                     timeout_err_q;

  logic [REGISTERS-1:0]     hit;
  logic                     any_hit;
  logic                     none_active;
  logic                     timeout_hit;
  logic [BUS_WIDTH-1:0]     selected_data;
  logic                     selected_error;
  logic                     respond;
  logic                     any_error;

  // Widen before comparing so BASE_ADDRESS+BYTE_SIZE may reach past the top of the address space.
  assign paddr_ext   = 64'(i_paddr);
  assign in_window   = (paddr_ext >= BASE_ADDRESS) && (paddr_ext < (BASE_ADDRESS + BYTE_SIZE));
  assign hit         = i_register_ready & i_register_active;
  assign any_hit     = |hit;
  assign none_active = ~|i_register_active;

  rggen_apb_response_mux #(
    .BUS_WIDTH (BUS_WIDTH),
    .REGISTERS (REGISTERS)
  ) u_response_mux (
    .hit            (hit),
    .read_data      (i_register_read_data),
    .status         (i_register_status),
    .selected_data  (selected_data),
    .selected_error (selected_error)
  );

`ifdef RGGEN_APB_ADAPTER_TIMEOUT_EN
  localparam int TIMEOUT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TIMEOUT_WIDTH-1:0] timeout_count;
  logic                     unused_inputs;

  assign unused_inputs = ^i_pprot;
  assign timeout_hit   = (timeout_count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Held at zero outside BUSY, so every BUSY entry starts counting from zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timeout_count <= '0;
    end else if (state != BUSY) begin
      timeout_count <= '0;
    end else begin
      timeout_count <= timeout_count + TIMEOUT_WIDTH'(1);
    end
  end
`else
  logic unused_inputs;

  assign unused_inputs = ^i_pprot ^ (TIMEOUT_CYCLES == 0);
  assign timeout_hit   = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_psel) begin
          state_next = in_window ? BUSY : RESPOND;
        end
      end
      BUSY: begin
        if (any_hit || none_active || timeout_hit) begin
          state_next = RESPOND;
        end
      end
      RESPOND: begin
        if (i_penable) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request fields are frozen at the setup phase; response flags are rebuilt for every transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      offset_q      <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      strobe_q      <= '0;
      rdata_q       <= '0;
      status_err_q  <= 1'b0;
      decode_err_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_psel) begin
            offset_q      <= ADDRESS_WIDTH'(paddr_ext - BASE_ADDRESS);
            write_q       <= i_pwrite;
            wdata_q       <= i_pwdata;
            strobe_q      <= i_pstrb;
            rdata_q       <= '0;
            status_err_q  <= 1'b0;
            decode_err_q  <= !in_window;
            timeout_err_q <= 1'b0;
          end
        end
        BUSY: begin
          if (any_hit) begin
            rdata_q      <= selected_data;
            status_err_q <= selected_error;
          end else if (none_active) begin
            decode_err_q <= 1'b1;
          end else if (timeout_hit) begin
            timeout_err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    respond   = (state == RESPOND) && i_penable;
    any_error = ((status_err_q || decode_err_q) && (ERROR_STATUS != 0)) || timeout_err_q;

    o_register_valid      = (state == BUSY);
    o_register_access     = access_code(write_q);
    o_register_address    = offset_q;
    o_register_write_data = wdata_q;
    o_register_strobe     = write_q ? strobe_q : '1;

    o_pready  = respond;
    o_pslverr = respond && any_error;
    o_prdata  = (respond && !write_q && !any_error) ? rdata_q : '0;
  end

endmodule

// File: tb/tb_rggen_apb_register_adapter.sv
// Testbench for rggen_apb_register_adapter: two instances (ERROR_STATUS=1 and 0) on shared stimulus.
// Timeout vectors are added when RGGEN_APB_ADAPTER_TIMEOUT_EN is defined.
module tb_rggen_apb_register_adapter;

  localparam int AW   = 12;
  localparam int BW   = 32;
  localparam int NR   = 2;
  localparam int TO   = 16;
  localparam int NONE = NR;

  typedef struct {
    logic        write;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          block;
    int          latency;
    logic        status_err;
    logic [31:0] rdata;
    int          exp_cycles;
    int          exp_valid;
    logic        exp_slverr_err;
    logic        exp_slverr_ok;
    logic [31:0] exp_prdata_err;
    logic [31:0] exp_prdata_ok;
  } vec_t;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_psel, i_penable, i_pwrite;
  logic [AW-1:0] i_paddr;
  logic [2:0]    i_pprot;
  logic [3:0]    i_pstrb;
  logic [BW-1:0] i_pwdata;
  logic [NR-1:0] i_register_active, i_register_ready;
  logic [2*NR-1:0]  i_register_status;
  logic [BW*NR-1:0] i_register_read_data;

  logic          err_pready, err_pslverr, err_valid;
  logic [BW-1:0] err_prdata, err_wdata;
  logic [1:0]    err_access;
  logic [AW-1:0] err_address;
  logic [3:0]    err_strobe;
  logic          ok_pready, ok_pslverr, ok_valid;
  logic [BW-1:0] ok_prdata, ok_wdata;
  logic [1:0]    ok_access;
  logic [AW-1:0] ok_address;
  logic [3:0]    ok_strobe;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  always #5 i_clk = ~i_clk;

  rggen_apb_register_adapter #(
    .ADDRESS_WIDTH(AW), .BASE_ADDRESS('h100), .BYTE_SIZE(256), .BUS_WIDTH(BW),
    .REGISTERS(NR), .ERROR_STATUS(1), .TIMEOUT_CYCLES(TO)
  ) dut_err (
    .i_clk(i_clk), .i_rst(i_rst), .i_psel(i_psel), .i_penable(i_penable), .i_pwrite(i_pwrite),
    .i_paddr(i_paddr), .i_pprot(i_pprot), .i_pstrb(i_pstrb), .i_pwdata(i_pwdata),
    .o_pready(err_pready), .o_pslverr(err_pslverr), .o_prdata(err_prdata),
    .o_register_valid(err_valid), .o_register_access(err_access), .o_register_address(err_address),
    .o_register_write_data(err_wdata), .o_register_strobe(err_strobe),
    .i_register_active(i_register_active), .i_register_ready(i_register_ready),
    .i_register_status(i_register_status), .i_register_read_data(i_register_read_data)
  );

  rggen_apb_register_adapter #(
    .ADDRESS_WIDTH(AW), .BASE_ADDRESS('h100), .BYTE_SIZE(256), .BUS_WIDTH(BW),
    .REGISTERS(NR), .ERROR_STATUS(0), .TIMEOUT_CYCLES(TO)
  ) dut_ok (
    .i_clk(i_clk), .i_rst(i_rst), .i_psel(i_psel), .i_penable(i_penable), .i_pwrite(i_pwrite),
    .i_paddr(i_paddr), .i_pprot(i_pprot), .i_pstrb(i_pstrb), .i_pwdata(i_pwdata),
    .o_pready(ok_pready), .o_pslverr(ok_pslverr), .o_prdata(ok_prdata),
    .o_register_valid(ok_valid), .o_register_access(ok_access), .o_register_address(ok_address),
    .o_register_write_data(ok_wdata), .o_register_strobe(ok_strobe),
    .i_register_active(i_register_active), .i_register_ready(i_register_ready),
    .i_register_status(i_register_status), .i_register_read_data(i_register_read_data)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic vec_t dir(input logic write, input logic [11:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input int block, input int latency,
                               input logic status_err, input logic [31:0] rdata,
                               input int cyc, input int valid, input logic se_err, input logic se_ok,
                               input logic [31:0] pd_err, input logic [31:0] pd_ok);
    vec_t v;
    v.write = write; v.addr = addr; v.wdata = wdata; v.strb = strb; v.block = block;
    v.latency = latency; v.status_err = status_err; v.rdata = rdata;
    v.exp_cycles = cyc; v.exp_valid = valid; v.exp_slverr_err = se_err; v.exp_slverr_ok = se_ok;
    v.exp_prdata_err = pd_err; v.exp_prdata_ok = pd_ok;
    return v;
  endfunction

  // Transaction-level reference: response timing and flags follow from window, block and latency.
  function automatic vec_t modelVec(input vec_t v);
    vec_t r = v;
    bit in_win = (v.addr >= 12'h100) && (v.addr < 12'h200);
    bit decode_err = 0, timeout = 0, status = 0;
    logic [31:0] data = '0;
    if (!in_win) begin
      r.exp_cycles = 1; r.exp_valid = 0; decode_err = 1;
    end else if (v.block >= NR) begin
      r.exp_cycles = 2; r.exp_valid = 1; decode_err = 1;
    end else if (v.latency == 0) begin
      r.exp_cycles = TO + 1; r.exp_valid = TO; timeout = 1;
    end else begin
      r.exp_cycles = v.latency + 1; r.exp_valid = v.latency; status = v.status_err; data = v.rdata;
    end
    r.exp_slverr_err = decode_err | status | timeout;
    r.exp_slverr_ok  = timeout;
    r.exp_prdata_err = (!v.write && !r.exp_slverr_err) ? data : '0;
    r.exp_prdata_ok  = (!v.write && !r.exp_slverr_ok) ? data : '0;
    return r;
  endfunction

  task automatic clearRegisters();
    i_register_active = '0; i_register_ready = '0;
    i_register_status = '0; i_register_read_data = '0;
  endtask

  task automatic driveRegisters(input vec_t v, input int n);
    clearRegisters();
    if (v.block < NR) begin
      i_register_active[v.block] = 1'b1;
      if (n == v.latency) begin
        i_register_ready[v.block] = 1'b1;
        i_register_read_data[v.block*BW +: BW] = v.rdata;
        i_register_status[2*v.block + 1] = v.status_err;
      end
    end
  endtask

  // Runs one APB transfer; entered and left at #1 after a rising edge.
  task automatic applyStimulus(input vec_t v, input string name);
    int n = 0, got = 0, valid_cnt = 0;
    bit req_checked = 0, early_bad = 0;
    logic ready_ok = 0, se_err = 0, se_ok = 0;
    logic [31:0] pd_err = '0, pd_ok = '0;
    i_psel = 1'b1; i_penable = 1'b0; i_pwrite = v.write; i_paddr = v.addr;
    i_pwdata = v.wdata; i_pstrb = v.strb; i_pprot = 3'($urandom);
    @(posedge i_clk); #1;
    i_penable = 1'b1;
    while (got == 0 && n < 40) begin
      n++;
      driveRegisters(v, n);
      @(negedge i_clk);
      if (err_valid) begin
        valid_cnt++;
        if (!req_checked) begin
          req_checked = 1;
          checkOutput({name, " access"}, 32'(err_access), v.write ? 32'd3 : 32'd2);
          checkOutput({name, " address"}, 32'(err_address), {20'd0, v.addr} - 32'h100);
          checkOutput({name, " strobe"}, 32'(err_strobe), v.write ? 32'(v.strb) : 32'hF);
          if (v.write) checkOutput({name, " wdata"}, err_wdata, v.wdata);
        end
      end
      if (err_pready) begin
        got = n; ready_ok = ok_pready; se_err = err_pslverr; se_ok = ok_pslverr;
        pd_err = err_prdata; pd_ok = ok_prdata;
      end else if (ok_pready || err_pslverr || ok_pslverr || err_prdata != 0 || ok_prdata != 0) begin
        early_bad = 1;
      end
      @(posedge i_clk); #1;
    end
    i_psel = 1'b0; i_penable = 1'b0;
    clearRegisters();
    checkOutput({name, " pready cycle"}, got, v.exp_cycles);
    checkOutput({name, " valid cycles"}, valid_cnt, v.exp_valid);
    checkOutput({name, " pready both"}, 32'(ready_ok), 32'(got != 0));
    checkOutput({name, " pslverr es1"}, 32'(se_err), 32'(v.exp_slverr_err));
    checkOutput({name, " pslverr es0"}, 32'(se_ok), 32'(v.exp_slverr_ok));
    checkOutput({name, " prdata es1"}, pd_err, v.exp_prdata_err);
    checkOutput({name, " prdata es0"}, pd_ok, v.exp_prdata_ok);
    checkOutput({name, " quiet before pready"}, 32'(early_bad), 0);
    @(negedge i_clk);
    checkOutput({name, " idle after"}, {28'd0, err_pready, err_valid, ok_pready, ok_valid}, 0);
    @(posedge i_clk); #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t rv;
    int bad;
    i_rst = 1'b1; i_psel = 0; i_penable = 0; i_pwrite = 0; i_paddr = '0; i_pprot = '0;
    i_pstrb = '0; i_pwdata = '0;
    clearRegisters();

    vecs.push_back(dir(1, 12'h104, 32'h0000_00A5, 4'b0001, 0, 1, 0, 32'h0, 2, 1, 0, 0, 32'h0, 32'h0));
    vecs.push_back(dir(0, 12'h108, 32'h0, 4'h0, 1, 4, 0, 32'hDEAD_BEEF, 5, 4, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
    vecs.push_back(dir(0, 12'h110, 32'h0, 4'h0, NONE, 1, 0, 32'h0, 2, 1, 1, 0, 32'h0, 32'h0));
    vecs.push_back(dir(0, 12'h080, 32'h0, 4'h0, NONE, 1, 0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0));
    vecs.push_back(dir(1, 12'h200, 32'hFFFF_FFFF, 4'hF, NONE, 1, 0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0));
    vecs.push_back(dir(0, 12'h0FF, 32'h0, 4'h0, NONE, 1, 0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0));
    vecs.push_back(dir(0, 12'h1FC, 32'h0, 4'h0, 0, 1, 0, 32'h1234_5678, 2, 1, 0, 0, 32'h1234_5678, 32'h1234_5678));
    vecs.push_back(dir(0, 12'h100, 32'h0, 4'h0, 0, 2, 1, 32'hCAFE_F00D, 3, 2, 1, 0, 32'h0, 32'hCAFE_F00D));
    vecs.push_back(dir(1, 12'h1F0, 32'h55AA_55AA, 4'b1010, 1, 3, 1, 32'h0, 4, 3, 1, 0, 32'h0, 32'h0));
`ifdef RGGEN_APB_ADAPTER_TIMEOUT_EN
    vecs.push_back(dir(0, 12'h140, 32'h0, 4'h0, 0, 0, 0, 32'h0BAD_F00D, TO + 1, TO, 1, 1, 32'h0, 32'h0));
`endif

    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("reset outputs es1", {29'd0, err_valid, err_pready, err_pslverr}, 0);
    checkOutput("reset prdata es1", err_prdata, 0);
    checkOutput("reset outputs es0", {29'd0, ok_valid, ok_pready, ok_pslverr}, 0);
    checkOutput("reset prdata es0", ok_prdata, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Response stays pending until the master raises penable.
    i_psel = 1'b1; i_penable = 1'b0; i_pwrite = 1'b0; i_paddr = 12'h300;
    @(posedge i_clk); #1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      if (err_pready || ok_pready) bad++;
      @(posedge i_clk); #1;
    end
    checkOutput("hold no pready", bad, 0);
    i_penable = 1'b1;
    @(negedge i_clk);
    checkOutput("hold pready", {30'd0, err_pready, ok_pready}, 32'h3);
    checkOutput("hold pslverr", {30'd0, err_pslverr, ok_pslverr}, 32'h2);
    @(posedge i_clk); #1;
    i_psel = 1'b0; i_penable = 1'b0;
    @(negedge i_clk);
    checkOutput("hold single pready", {30'd0, err_pready, ok_pready}, 0);
    @(posedge i_clk); #1;

    // Reset during the second BUSY cycle abandons the transfer.
    rv = modelVec(dir(0, 12'h120, 32'h0, 4'h0, 0, 10, 0, 32'h7777_7777, 0, 0, 0, 0, 0, 0));
    i_psel = 1'b1; i_penable = 1'b0; i_pwrite = 1'b0; i_paddr = rv.addr;
    @(posedge i_clk); #1;
    i_penable = 1'b1;
    driveRegisters(rv, 1);
    @(negedge i_clk);
    checkOutput("rst busy1 valid", {31'd0, err_valid}, 1);
    @(posedge i_clk); #1;
    driveRegisters(rv, 2);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_psel = 1'b0; i_penable = 1'b0;
    clearRegisters();
    @(negedge i_clk);
    checkOutput("rst drops valid", {30'd0, err_valid, ok_valid}, 0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (err_pready || ok_pready || err_valid || ok_valid) bad++;
      @(negedge i_clk);
    end
    checkOutput("rst no response", bad, 0);
    @(posedge i_clk); #1;

    for (int i = 0; i < 24; i++) begin
      rv.write = 1'($urandom);
      rv.addr = 12'($urandom_range(0, 'h2FF));
      rv.wdata = $urandom;
      rv.strb = 4'($urandom);
      rv.block = $urandom_range(0, NR);
      rv.latency = $urandom_range(1, 5);
      rv.status_err = 1'($urandom);
      rv.rdata = $urandom;
      applyStimulus(modelVec(rv), $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
